// File: rtl/pipe_mem_stage.sv
// rtl/pipe_mem_stage.sv - MEM stage: E/M register, data-memory handshake FSM, M/W register
// Optional alignment check enabled by defining PIPE_MEM_ALIGN_CHK_EN.
module pipe_mem_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ewreg_i,
    input  logic        em2reg_i,
    input  logic        ewmem_i,
    input  logic [31:0] ealu_i,
    input  logic [31:0] eb_i,
    input  logic [4:0]  ern_i,
    output logic        mstall_o,
    output logic        em_wreg_o,
    output logic        em_m2reg_o,
    output logic [4:0]  em_rn_o,
    output logic [31:0] em_alu_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        wwreg_o,
    output logic        wm2reg_o,
    output logic [4:0]  wrn_o,
    output logic [31:0] walu_o,
    output logic [31:0] wmo_o,
    output logic        mem_err_o,
    output logic        misalign_o
);

    localparam int CW = $clog2(MAX_WAIT + 2);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          em_wreg_q, em_wreg_d, em_m2reg_q, em_m2reg_d, em_wmem_q, em_wmem_d;
    logic          em_mis_q, em_mis_d;
    logic [4:0]    em_rn_q, em_rn_d;
    logic [31:0]   em_alu_q, em_alu_d, em_b_q, em_b_d;
    logic          wwreg_q, wwreg_d, wm2reg_q, wm2reg_d;
    logic [4:0]    wrn_q, wrn_d;
    logic [31:0]   walu_q, walu_d, wmo_q, wmo_d;
    logic          mem_err_q;

    logic e_memop, e_mis, access, abort, mstall, load_done;

    assign e_memop = ewmem_i | em2reg_i;
`ifdef PIPE_MEM_ALIGN_CHK_EN
    assign e_mis = e_memop & (ealu_i[1:0] != 2'b00);
`else
    assign e_mis = 1'b0;
`endif

    assign access    = (state_q == ACCESS);
    assign abort     = (MAX_WAIT != 0) && access && !dmem_ack_i
                       && (cnt_q == CW'(MAX_WAIT - 1));
    assign mstall    = access & ~dmem_ack_i & ~abort;
    // A combined load+store is treated as a store, so its read data is dropped.
    assign load_done = access & dmem_ack_i & em_m2reg_q & ~em_wmem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        em_wreg_d  = em_wreg_q;
        em_m2reg_d = em_m2reg_q;
        em_wmem_d  = em_wmem_q;
        em_mis_d   = em_mis_q;
        em_rn_d    = em_rn_q;
        em_alu_d   = em_alu_q;
        em_b_d     = em_b_q;
        wwreg_d    = wwreg_q;
        wm2reg_d   = wm2reg_q;
        wrn_d      = wrn_q;
        walu_d     = walu_q;
        wmo_d      = wmo_q;
        if (mstall) begin
            cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
            wwreg_d  = 1'b0;
            wm2reg_d = 1'b0;
        end else begin
            // Completion and load of the next op share one edge: back-to-back without a gap.
            state_d    = (e_memop & ~e_mis) ? ACCESS : IDLE;
            cnt_d      = '0;
            em_wreg_d  = ewreg_i;
            em_m2reg_d = em2reg_i;
            em_wmem_d  = ewmem_i;
            em_mis_d   = e_mis;
            em_rn_d    = ern_i;
            em_alu_d   = ealu_i;
            em_b_d     = eb_i;
            wwreg_d    = em_wreg_q & ~abort & ~em_mis_q;
            wm2reg_d   = em_m2reg_q & ~abort & ~em_mis_q;
            wrn_d      = em_rn_q;
            walu_d     = em_alu_q;
            wmo_d      = load_done ? dmem_rdata_i : 32'h0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            em_wreg_q  <= 1'b0;
            em_m2reg_q <= 1'b0;
            em_wmem_q  <= 1'b0;
            em_mis_q   <= 1'b0;
            em_rn_q    <= 5'h0;
            em_alu_q   <= 32'h0;
            em_b_q     <= 32'h0;
            wwreg_q    <= 1'b0;
            wm2reg_q   <= 1'b0;
            wrn_q      <= 5'h0;
            walu_q     <= 32'h0;
            wmo_q      <= 32'h0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            em_wreg_q  <= em_wreg_d;
            em_m2reg_q <= em_m2reg_d;
            em_wmem_q  <= em_wmem_d;
            em_mis_q   <= em_mis_d;
            em_rn_q    <= em_rn_d;
            em_alu_q   <= em_alu_d;
            em_b_q     <= em_b_d;
            wwreg_q    <= wwreg_d;
            wm2reg_q   <= wm2reg_d;
            wrn_q      <= wrn_d;
            walu_q     <= walu_d;
            wmo_q      <= wmo_d;
            mem_err_q  <= abort;
        end
    end

    assign mstall_o     = mstall;
    assign em_wreg_o    = em_wreg_q;
    assign em_m2reg_o   = em_m2reg_q;
    assign em_rn_o      = em_rn_q;
    assign em_alu_o     = em_alu_q;
    assign dmem_req_o   = access;
    assign dmem_we_o    = em_wmem_q;
    assign dmem_addr_o  = em_alu_q;
    assign dmem_wdata_o = em_b_q;
    assign wwreg_o      = wwreg_q;
    assign wm2reg_o     = wm2reg_q;
    assign wrn_o        = wrn_q;
    assign walu_o       = walu_q;
    assign wmo_o        = wmo_q;
    assign mem_err_o    = mem_err_q;
    assign misalign_o   = em_mis_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb/tb_pipe_mem_stage.sv - self-checking bench for pipe_mem_stage (MAX_WAIT = 4)
module tb_pipe_mem_stage;

    localparam int MW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
    logic [31:0] ealu = '0, eb = '0;
    logic [4:0]  ern = '0;
    logic        mstall, em_wreg, em_m2reg;
    logic [4:0]  em_rn;
    logic [31:0] em_alu;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        wwreg, wm2reg;
    logic [4:0]  wrn;
    logic [31:0] walu, wmo;
    logic        mem_err, misalign;

    always #5 clock = ~clock;

    pipe_mem_stage #(.MAX_WAIT(MW)) dut (
        .clock_i(clock), .reset_i(reset),
        .ewreg_i(ewreg), .em2reg_i(em2reg), .ewmem_i(ewmem),
        .ealu_i(ealu), .eb_i(eb), .ern_i(ern),
        .mstall_o(mstall),
        .em_wreg_o(em_wreg), .em_m2reg_o(em_m2reg), .em_rn_o(em_rn), .em_alu_o(em_alu),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack),
        .wwreg_o(wwreg), .wm2reg_o(wm2reg), .wrn_o(wrn), .walu_o(walu), .wmo_o(wmo),
        .mem_err_o(mem_err), .misalign_o(misalign)
    );

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
        int          lat;
        logic [31:0] rdata;
        logic        x_wwreg;
        logic        x_wm2reg;
        logic [31:0] x_wmo;
        int          x_stall;
        logic        x_err;
        logic        x_mis;
    } vec_t;

    vec_t prog[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wreg, input logic m2reg, input logic wmem,
                                input logic [31:0] alu, input logic [31:0] b,
                                input logic [4:0] rn, input int lat, input logic [31:0] rdata,
                                input logic x_wwreg, input logic x_wm2reg,
                                input logic [31:0] x_wmo, input int x_stall,
                                input logic x_err, input logic x_mis);
        vec_t v;
        v.wreg = wreg; v.m2reg = m2reg; v.wmem = wmem; v.alu = alu; v.b = b; v.rn = rn;
        v.lat = lat; v.rdata = rdata; v.x_wwreg = x_wwreg; v.x_wm2reg = x_wm2reg;
        v.x_wmo = x_wmo; v.x_stall = x_stall; v.x_err = x_err; v.x_mis = x_mis;
        return v;
    endfunction

    // Instruction-level reference: outcome follows from op kind, alignment and memory latency.
    function automatic vec_t model(input vec_t v);
        logic memop, mis, tmo, dead;
        memop = v.wmem | v.m2reg;
        mis   = 1'b0;
`ifdef PIPE_MEM_ALIGN_CHK_EN
        mis   = memop && (v.alu % 4 != 0);
`endif
        tmo   = memop && !mis && (v.lat >= MW);
        dead  = mis || tmo;
        v.x_mis    = mis;
        v.x_err    = tmo;
        v.x_stall  = (!memop || mis) ? 0 : (tmo ? MW - 1 : v.lat);
        v.x_wwreg  = v.wreg && !dead;
        v.x_wm2reg = v.m2reg && !dead;
        v.x_wmo    = (v.m2reg && !v.wmem && !dead) ? v.rdata : 32'h0;
        return v;
    endfunction

    task automatic drive_e(input int idx);
        if (idx < prog.size()) begin
            ewreg = prog[idx].wreg; em2reg = prog[idx].m2reg; ewmem = prog[idx].wmem;
            ealu = prog[idx].alu; eb = prog[idx].b; ern = prog[idx].rn;
        end else begin
            ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0; ealu = '0; eb = '0; ern = '0;
        end
    endtask

    // Entered 1 time unit after an edge with an empty (all-zero) E/M register.
    task automatic run_prog();
        vec_t v, pv;
        bit   have_prev;
        logic memop;
        int   d;
        have_prev = 0;
        pv = prog[0];
        drive_e(0);
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        #2;
        chk("rst_mstall", mstall, 0);  chk("rst_req", dmem_req, 0);
        chk("rst_mem_err", mem_err, 0); chk("rst_misalign", misalign, 0);
        chk("rst_wwreg", wwreg, 0);    chk("rst_wm2reg", wm2reg, 0);
        chk("rst_wrn", wrn, 0);        chk("rst_walu", walu, 0);   chk("rst_wmo", wmo, 0);
        chk("rst_em_wreg", em_wreg, 0); chk("rst_em_m2reg", em_m2reg, 0);
        chk("rst_em_rn", em_rn, 0);    chk("rst_em_alu", em_alu, 0);
        @(posedge clock); #1;
        for (int i = 0; i < prog.size(); i++) begin
            v = prog[i];
            memop = (v.wmem | v.m2reg) & ~v.x_mis;
            d = v.x_stall + 1;
            for (int c = 1; c <= d; c++) begin
                drive_e(i + 1);
                dmem_ack = memop && !v.x_err && (c == v.lat + 1);
                dmem_rdata = dmem_ack ? v.rdata : $urandom;
                #2;
                chk("mstall", mstall, (c < d));
                chk("dmem_req", dmem_req, memop);
                if (memop) begin
                    chk("dmem_we", dmem_we, v.wmem);
                    chk("dmem_addr", dmem_addr, v.alu);
                    chk("dmem_wdata", dmem_wdata, v.b);
                end
                chk("em_wreg", em_wreg, v.wreg);
                chk("em_rn", em_rn, v.rn);
                chk("em_alu", em_alu, v.alu);
                chk("misalign", misalign, v.x_mis);
                if (c == 1) begin
                    chk("mem_err", mem_err, have_prev && pv.x_err);
                    if (have_prev) begin
                        chk("wwreg", wwreg, pv.x_wwreg);
                        chk("wm2reg", wm2reg, pv.x_wm2reg);
                        if (!(pv.x_err || pv.x_mis)) begin
                            chk("wrn", wrn, pv.rn);
                            chk("walu", walu, pv.alu);
                            chk("wmo", wmo, pv.x_wmo);
                        end
                    end else begin
                        chk("wwreg_first", wwreg, 0);
                        chk("wm2reg_first", wm2reg, 0);
                    end
                end else begin
                    chk("bubble_wwreg", wwreg, 0);
                    chk("bubble_wm2reg", wm2reg, 0);
                    chk("bubble_mem_err", mem_err, 0);
                end
                @(posedge clock); #1;
            end
            pv = v;
            have_prev = 1;
        end
        drive_e(prog.size());
        dmem_ack = 1'b0;
        #2;
        chk("drain_mstall", mstall, 0);
        chk("drain_mem_err", mem_err, pv.x_err);
        chk("drain_wwreg", wwreg, pv.x_wwreg);
        chk("drain_wm2reg", wm2reg, pv.x_wm2reg);
        if (!(pv.x_err || pv.x_mis)) begin
            chk("drain_walu", walu, pv.alu);
            chk("drain_wmo", wmo, pv.x_wmo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        int   k;
        prog.push_back(mk(1, 0, 0, 32'h1234, 32'h0, 5, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0));
        prog.push_back(mk(1, 1, 0, 32'h40, 32'h0, 3, 0, 32'hCAFE, 1, 1, 32'hCAFE, 0, 0, 0));
        prog.push_back(mk(0, 0, 1, 32'h80, 32'hBEEF, 0, 3, 32'h0, 0, 0, 32'h0, 3, 0, 0));
        prog.push_back(mk(1, 1, 0, 32'h90, 32'h0, 7, 99, 32'h1111, 0, 0, 32'h0, 3, 1, 0));
        prog.push_back(mk(1, 0, 0, 32'h55, 32'h0, 8, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0));
        prog.push_back(mk(1, 1, 0, 32'h44, 32'h0, 9, 1, 32'hA5A50001, 1, 1, 32'hA5A50001, 1, 0, 0));
        prog.push_back(mk(1, 1, 0, 32'h48, 32'h0, 10, 0, 32'hBEAD, 1, 1, 32'hBEAD, 0, 0, 0));
        prog.push_back(mk(1, 1, 0, 32'h4C, 32'h0, 11, 3, 32'h13579BDF, 1, 1, 32'h13579BDF, 3, 0, 0));
        prog.push_back(mk(1, 1, 1, 32'hC0, 32'hD00D, 12, 2, 32'hFFFFFFFF, 1, 1, 32'h0, 2, 0, 0));
`ifdef PIPE_MEM_ALIGN_CHK_EN
        prog.push_back(mk(1, 1, 0, 32'h42, 32'h0, 13, 0, 32'h2222, 0, 0, 32'h0, 0, 0, 1));
`else
        prog.push_back(mk(1, 1, 0, 32'h42, 32'h0, 13, 0, 32'h2222, 1, 1, 32'h2222, 0, 0, 0));
`endif
        prog.push_back(mk(1, 0, 0, 32'hFFFFFFFF, 32'h0, 31, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0));

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 5);
            rv.wreg  = 1'($urandom);
            rv.m2reg = (k == 2) || (k == 4);
            rv.wmem  = (k == 3) || (k == 4);
            rv.alu   = $urandom;
            if ($urandom_range(0, 3) != 0) rv.alu[1:0] = 2'b00;
            rv.b     = $urandom;
            rv.rn    = 5'($urandom);
            rv.lat   = $urandom_range(0, 5);
            rv.rdata = $urandom;
            prog.push_back(model(rv));
        end

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        run_prog();

        // Reset while a load is pending in its second ACCESS cycle.
        @(posedge clock); #1;
        ewreg = 1'b1; em2reg = 1'b1; ewmem = 1'b0; ealu = 32'h100; eb = '0; ern = 5'd4;
        dmem_ack = 1'b0;
        @(posedge clock); #1;
        drive_e(prog.size());
        #2;
        chk("t5_req_c1", dmem_req, 1);
        chk("t5_stall_c1", mstall, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        #2;
        chk("t5_req_c2", dmem_req, 1);
        @(posedge clock); #2;
        chk("t5_req_after", dmem_req, 0);
        chk("t5_mstall", mstall, 0);
        chk("t5_mem_err", mem_err, 0);
        chk("t5_wwreg", wwreg, 0);
        chk("t5_wm2reg", wm2reg, 0);
        chk("t5_wrn", wrn, 0);
        chk("t5_walu", walu, 0);
        chk("t5_wmo", wmo, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #3;
            chk("t5_post_mem_err", mem_err, 0);
            chk("t5_post_req", dmem_req, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
